// File: rtl/os_receiver_pkg.sv
// Shared ordered-set definitions (os_pkg): type encodings, symbol constants,
// TS header fields and the classification helpers used by Rx and Tx.
package os_pkg;

  typedef enum logic [2:0] {
    OS_TS1     = 3'd0,
    OS_TS2     = 3'd1,
    OS_SDS     = 3'd2,
    OS_CTL_SKP = 3'd3,
    OS_EIOS    = 3'd4,
    OS_EIEOS   = 3'd5,
    OS_UNKNOWN = 3'd7
  } os_type_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_REPORT
  } rx_state_e;

  localparam logic [7:0] SYM_COM      = 8'hBC;
  localparam logic [7:0] SYM_PAD      = 8'hF7;
  localparam logic [7:0] SYM_EIOS_LG  = 8'h7C;
  localparam logic [7:0] SYM_SKP_LG   = 8'h1C;
  localparam logic [7:0] SYM_TS1_HG   = 8'h1E;
  localparam logic [7:0] SYM_TS2_HG   = 8'h2D;
  localparam logic [7:0] SYM_TS1_ID   = 8'h4A;
  localparam logic [7:0] SYM_TS2_ID   = 8'h45;
  localparam logic [7:0] SYM_SDS      = 8'hE1;
  localparam logic [7:0] SYM_SDS_BODY = 8'h87;
  localparam logic [7:0] SYM_SKP_HG   = 8'h99;
  localparam logic [7:0] SYM_SKP_END  = 8'h78;
  localparam logic [7:0] SYM_EIEOS_LO = 8'h00;
  localparam logic [7:0] SYM_EIEOS_HI = 8'hFF;

  typedef logic [15:0][7:0] os_syms_t;

  typedef struct packed {
    logic [7:0] link_num;
    logic [7:0] lane_num;
    logic       link_pad;
    logic       lane_pad;
    logic       speed_change;
  } ts_fields_t;

  typedef struct packed {
    os_type_e os_type;
    logic     err;
  } os_class_t;

  function automatic logic is_short_set(logic gen, logic k0, logic [7:0] s0, logic [7:0] s1);
    return !gen && k0 && (s0 == SYM_COM) && ((s1 == SYM_EIOS_LG) || (s1 == SYM_SKP_LG));
  endfunction

  function automatic logic ts_id_ok(os_syms_t s, logic [7:0] id);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 6; i < 16; i++) if (s[i] != id) ok = 1'b0;
    return ok;
  endfunction

  function automatic os_class_t classify(logic gen, logic k0, os_syms_t s);
    os_class_t c;
    logic      ok;
    c.os_type = OS_UNKNOWN;
    ok        = 1'b0;
    if (!gen) begin
      if (k0 && (s[0] == SYM_COM)) begin
        if (s[1] == SYM_EIOS_LG) begin
          c.os_type = OS_EIOS; ok = 1'b1;
        end else if (s[1] == SYM_SKP_LG) begin
          c.os_type = OS_CTL_SKP; ok = 1'b1;
        end else if (ts_id_ok(s, SYM_TS1_ID)) begin
          c.os_type = OS_TS1; ok = 1'b1;
        end else if (ts_id_ok(s, SYM_TS2_ID)) begin
          c.os_type = OS_TS2; ok = 1'b1;
        end
      end
    end else begin
      case (s[0])
        SYM_TS1_HG: begin c.os_type = OS_TS1; ok = ts_id_ok(s, SYM_TS1_ID); end
        SYM_TS2_HG: begin c.os_type = OS_TS2; ok = ts_id_ok(s, SYM_TS2_ID); end
        SYM_SDS: begin
          c.os_type = OS_SDS; ok = 1'b1;
          for (int unsigned i = 1; i < 16; i++) if (s[i] != SYM_SDS_BODY) ok = 1'b0;
        end
        SYM_SKP_HG: begin
          c.os_type = OS_CTL_SKP;
          ok = (s[12] == SYM_SKP_END) || (s[12] == SYM_SDS);
          for (int unsigned i = 1; i < 12; i++) if (s[i] != SYM_SKP_HG) ok = 1'b0;
        end
        SYM_EIEOS_LO: begin
          c.os_type = OS_EIEOS; ok = 1'b1;
          for (int unsigned i = 0; i < 16; i++)
            if (s[i] != (((i & 4) != 0) ? SYM_EIEOS_HI : SYM_EIEOS_LO)) ok = 1'b0;
        end
        default: ok = 1'b0;
      endcase
    end
    if (!ok) c.os_type = OS_UNKNOWN;
    c.err = !ok;
    return c;
  endfunction

  function automatic ts_fields_t get_ts_fields(os_syms_t s);
    ts_fields_t f;
    f.link_num     = s[1];
    f.lane_num     = s[2];
    f.link_pad     = (s[1] == SYM_PAD);
    f.lane_pad     = (s[2] == SYM_PAD);
    f.speed_change = s[4][0];
    return f;
  endfunction

endpackage

// File: rtl/os_receiver_if.sv
// Symbol-time stream carrying one symbol per lane into the ordered-set receiver.
interface os_receiver_if #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned MAX_LANES  = 32
);
  logic [0:DATA_WIDTH-1] i_OS;
  logic [MAX_LANES-1:0]  i_K;
  logic                  i_valid;
  logic                  i_os_start;

  modport master (output i_OS, i_K, i_valid, i_os_start);
  modport slave  (input  i_OS, i_K, i_valid, i_os_start);
endinterface

// File: rtl/os_receiver_consec_counter.sv
// Consecutive-identical-TS counter: compares each valid TS with the previous
// one and keeps a saturating count plus the ">= 8" flag for the LTSSM.
module os_consec_counter
  import os_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cnt_rst,
  input  logic                 ts_ev,
  input  logic                 bad_ev,
  input  os_type_e             ts_type,
  input  ts_fields_t           fields,
  output logic [CNT_WIDTH-1:0] o_consec_cnt,
  output logic                 o_ts_8
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ts_8_q, ts_8_d;
  os_type_e             prev_type_q, prev_type_d;
  ts_fields_t           prev_q, prev_d;

  // After reset or a clear the count is 0, so a "match" still loads 1.
  always_comb begin
    cnt_d       = cnt_q;
    prev_d      = prev_q;
    prev_type_d = prev_type_q;
    if (ts_ev) begin
      prev_d      = fields;
      prev_type_d = ts_type;
      if ((ts_type == prev_type_q) && (fields == prev_q))
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);
      else
        cnt_d = CNT_WIDTH'(1);
    end else if (bad_ev) begin
      cnt_d = '0;
    end
    if (cnt_rst) cnt_d = '0;
    ts_8_d = (cnt_d >= CNT_WIDTH'(8));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q       <= '0;
      ts_8_q      <= 1'b0;
      prev_type_q <= OS_TS1;
      prev_q      <= '0;
    end else begin
      cnt_q       <= cnt_d;
      ts_8_q      <= ts_8_d;
      prev_type_q <= prev_type_d;
      prev_q      <= prev_d;
    end
  end

  assign o_consec_cnt = cnt_q;
  assign o_ts_8       = ts_8_q;

endmodule

// File: rtl/os_receiver.sv
// Ordered-set receiver: delimits, classifies and reports 4/16-symbol sets.
// Define OS_RX_LANE_CHECK_EN to require every lane to match lane 0.
module os_receiver
  import os_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 256,
  parameter int unsigned MAX_LANES      = 32,
  parameter int unsigned LINK_NUM_WIDTH = 8,
  parameter int unsigned CONFIG_WIDTH   = 3,
  parameter int unsigned CNT_WIDTH      = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  os_receiver_if.slave              os_if,
  input  logic                      gen,
  input  logic                      cnt_rst,
  output logic [CONFIG_WIDTH-1:0]   o_type,
  output logic                      o_os_valid,
  output logic [LINK_NUM_WIDTH-1:0] o_link_num,
  output logic [7:0]                o_lane_num,
  output logic                      o_link_pad,
  output logic                      o_lane_pad,
  output logic                      o_speed_change,
  output logic [CNT_WIDTH-1:0]      o_consec_cnt,
  output logic                      o_ts_8,
  output logic                      o_err
);

  localparam int unsigned NUM_LANES = DATA_WIDTH / 8;

  rx_state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  os_syms_t   sym_q, sym_d, sym_next;
  logic       k0_q, k0_d, gen_q, gen_d, lane_bad_q, lane_bad_d;
  os_type_e   type_q, type_d;
  ts_fields_t fields_q, fields_d;
  logic       os_valid_q, os_valid_d, err_q, err_d;
  logic       ts_ev, bad_ev, capture, start, lane_mis, lane_bad_next;
  logic [7:0] cur;
  logic [3:0] last_idx;
  os_class_t  cls;
  logic       unused_lanes;

  assign cur   = os_if.i_OS[0:7];
  assign start = os_if.i_valid && os_if.i_os_start;

  always_comb begin
    lane_mis = 1'b0;
`ifdef OS_RX_LANE_CHECK_EN
    for (int unsigned l = 1; l < NUM_LANES; l++)
      if (os_if.i_OS[l*8 +: 8] != cur) lane_mis = 1'b1;
`endif
  end

`ifdef OS_RX_LANE_CHECK_EN
  assign unused_lanes = ^os_if.i_K[MAX_LANES-1:1];
`else
  assign unused_lanes = ^{os_if.i_OS[8:NUM_LANES*8-1], os_if.i_K[MAX_LANES-1:1]};
`endif

  // Symbols 1-2 carry per-lane link/lane numbers, so they are not cross-checked.
  always_comb begin
    sym_next         = sym_q;
    sym_next[cnt_q]  = cur;
    lane_bad_next    = lane_bad_q || (lane_mis && (cnt_q >= 4'd3));
    last_idx         = is_short_set(gen_q, k0_q, sym_next[0], sym_next[1]) ? 4'd3 : 4'd15;
    cls              = classify(gen_q, k0_q, sym_next);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sym_d      = sym_q;
    k0_d       = k0_q;
    gen_d      = gen_q;
    lane_bad_d = lane_bad_q;
    type_d     = type_q;
    fields_d   = fields_q;
    os_valid_d = 1'b0;
    err_d      = 1'b0;
    ts_ev      = 1'b0;
    bad_ev     = 1'b0;
    capture    = 1'b0;
    case (state_q)
      ST_IDLE: capture = start;
      ST_COLLECT: begin
        if (os_if.i_valid) begin
          if (os_if.i_os_start) begin
            // Aborted set counts as errored: pulse o_err, clear the count, restart.
            err_d   = 1'b1;
            bad_ev  = 1'b1;
            capture = 1'b1;
          end else begin
            sym_d      = sym_next;
            lane_bad_d = lane_bad_next;
            cnt_d      = cnt_q + 4'd1;
            if (cnt_q == last_idx) begin
              state_d    = ST_REPORT;
              os_valid_d = 1'b1;
              if (cls.err || lane_bad_next) begin
                type_d = OS_UNKNOWN;
                err_d  = 1'b1;
                bad_ev = 1'b1;
              end else begin
                type_d = cls.os_type;
                if ((cls.os_type == OS_TS1) || (cls.os_type == OS_TS2)) begin
                  fields_d = get_ts_fields(sym_next);
                  ts_ev    = 1'b1;
                end
              end
            end
          end
        end
      end
      ST_REPORT: begin
        state_d = ST_IDLE;
        capture = start;
      end
      default: state_d = ST_IDLE;
    endcase
    if (capture) begin
      state_d    = ST_COLLECT;
      sym_d      = '0;
      sym_d[0]   = cur;
      k0_d       = os_if.i_K[0];
      gen_d      = gen;
      lane_bad_d = lane_mis;
      cnt_d      = 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      sym_q      <= '0;
      k0_q       <= 1'b0;
      gen_q      <= 1'b0;
      lane_bad_q <= 1'b0;
      type_q     <= OS_UNKNOWN;
      fields_q   <= '0;
      os_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sym_q      <= sym_d;
      k0_q       <= k0_d;
      gen_q      <= gen_d;
      lane_bad_q <= lane_bad_d;
      type_q     <= type_d;
      fields_q   <= fields_d;
      os_valid_q <= os_valid_d;
      err_q      <= err_d;
    end
  end

  os_consec_counter #(.CNT_WIDTH(CNT_WIDTH)) u_consec (
    .clk          (clk),
    .rst          (rst),
    .cnt_rst      (cnt_rst),
    .ts_ev        (ts_ev),
    .bad_ev       (bad_ev),
    .ts_type      (cls.os_type),
    .fields       (get_ts_fields(sym_next)),
    .o_consec_cnt (o_consec_cnt),
    .o_ts_8       (o_ts_8)
  );

  assign o_type         = CONFIG_WIDTH'(type_q);
  assign o_os_valid     = os_valid_q;
  assign o_err          = err_q;
  assign o_link_num     = LINK_NUM_WIDTH'(fields_q.link_num);
  assign o_lane_num     = fields_q.lane_num;
  assign o_link_pad     = fields_q.link_pad;
  assign o_lane_pad     = fields_q.lane_pad;
  assign o_speed_change = fields_q.speed_change;

endmodule

// File: tb/tb_os_receiver.sv
// Directed bench for os_receiver: a table of back-to-back ordered sets plus
// hand-written abort, gap, counter-clear and gen-hold sequences.
module tb_os_receiver;

  localparam int DW = 256;
  localparam int ML = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       gen = 1'b0;
  logic       cnt_rst = 1'b0;
  logic [2:0] o_type;
  logic       o_os_valid, o_link_pad, o_lane_pad, o_speed_change, o_ts_8, o_err;
  logic [7:0] o_link_num, o_lane_num;
  logic [9:0] o_consec_cnt;

  os_receiver_if #(.DATA_WIDTH(DW), .MAX_LANES(ML)) os_if ();

  os_receiver #(
    .DATA_WIDTH(DW), .MAX_LANES(ML), .LINK_NUM_WIDTH(8), .CONFIG_WIDTH(3), .CNT_WIDTH(10)
  ) dut (
    .clk(clk), .rst(rst), .os_if(os_if), .gen(gen), .cnt_rst(cnt_rst),
    .o_type(o_type), .o_os_valid(o_os_valid), .o_link_num(o_link_num),
    .o_lane_num(o_lane_num), .o_link_pad(o_link_pad), .o_lane_pad(o_lane_pad),
    .o_speed_change(o_speed_change), .o_consec_cnt(o_consec_cnt), .o_ts_8(o_ts_8),
    .o_err(o_err)
  );

  always #5 clk = ~clk;

  typedef enum int {K_TS1H, K_TS2H, K_SDS, K_SKPH, K_EIEOS,
                    K_TS1L, K_TS2L, K_EIOS, K_SKPL, K_GARB} kind_e;

  typedef struct {
    kind_e      kind;
    bit         gen;
    logic [7:0] link;
    logic [7:0] lane;
    bit         spd;
    int         cor_lane;
    int         cor_idx;
    logic [7:0] cor_val;
    logic [2:0] e_type;
    bit         e_err;
    logic [7:0] e_link;
    logic [7:0] e_lane;
    bit         e_spd;
    int         e_cnt;
  } vec_t;

  int n_tests = 0, n_fail = 0;
  int n_pulses = 0, n_errs = 0, exp_pulses = 0, exp_errs = 0;
  vec_t tbl [25];

  always @(negedge clk) if (rst) begin
    if (o_os_valid) n_pulses++;
    if (o_err) n_errs++;
  end

  function automatic vec_t mk(kind_e k, bit g, logic [7:0] link, logic [7:0] lane, bit spd,
                              int cl, int ci, logic [7:0] cv, logic [2:0] et, bit ee,
                              logic [7:0] el, logic [7:0] ela, bit es, int ec);
    vec_t v;
    v.kind = k; v.gen = g; v.link = link; v.lane = lane; v.spd = spd;
    v.cor_lane = cl; v.cor_idx = ci; v.cor_val = cv;
    v.e_type = et; v.e_err = ee; v.e_link = el; v.e_lane = ela; v.e_spd = es; v.e_cnt = ec;
    return v;
  endfunction

  function automatic bit is_ts(kind_e k);
    return (k == K_TS1H) || (k == K_TS2H) || (k == K_TS1L) || (k == K_TS2L);
  endfunction

  function automatic int len_of(kind_e k);
    return ((k == K_EIOS) || (k == K_SKPL)) ? 4 : 16;
  endfunction

  function automatic logic kflag(kind_e k, int idx);
    if ((k == K_EIOS) || (k == K_SKPL)) return 1'b1;
    return ((k == K_TS1L) || (k == K_TS2L)) && (idx == 0);
  endfunction

  function automatic logic [7:0] sym_of(kind_e k, int idx, logic [7:0] link,
                                        logic [7:0] lane, bit spd);
    if (is_ts(k)) begin
      case (idx)
        0: return (k == K_TS1H) ? 8'h1E : (k == K_TS2H) ? 8'h2D : 8'hBC;
        1: return link;
        2: return lane;
        3, 5: return 8'h00;
        4: return {7'd0, spd};
        default: return ((k == K_TS1H) || (k == K_TS1L)) ? 8'h4A : 8'h45;
      endcase
    end
    case (k)
      K_SDS:   return (idx == 0) ? 8'hE1 : 8'h87;
      K_SKPH:  return (idx <= 11) ? 8'h99 : (idx == 12) ? 8'h78 : 8'h00;
      K_EIEOS: return (((idx / 4) % 2) == 1) ? 8'hFF : 8'h00;
      K_EIOS:  return (idx == 0) ? 8'hBC : 8'h7C;
      K_SKPL:  return (idx == 0) ? 8'hBC : 8'h1C;
      default: return (idx >= 6) ? 8'h4A : 8'h00;
    endcase
  endfunction

  task automatic put_sym(input vec_t v, input int idx, input bit start);
    logic [7:0] b, bl;
    b = sym_of(v.kind, idx, v.link, v.lane, v.spd);
    for (int l = 0; l < ML; l++) begin
      bl = b;
      if ((idx == 2) && is_ts(v.kind) && (b != 8'hF7)) bl = b + 8'(l);
      if ((l == v.cor_lane) && (idx == v.cor_idx)) bl = v.cor_val;
      os_if.i_OS[l*8 +: 8] = bl;
      os_if.i_K[l] = kflag(v.kind, idx);
    end
    os_if.i_valid    = 1'b1;
    os_if.i_os_start = start;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    chk({tag, " os_valid"}, int'(o_os_valid), 1);
    chk({tag, " type"}, int'(o_type), int'(v.e_type));
    chk({tag, " err"}, int'(o_err), int'(v.e_err));
    chk({tag, " link_num"}, int'(o_link_num), int'(v.e_link));
    chk({tag, " lane_num"}, int'(o_lane_num), int'(v.e_lane));
    chk({tag, " link_pad"}, int'(o_link_pad), int'(v.e_link == 8'hF7));
    chk({tag, " lane_pad"}, int'(o_lane_pad), int'(v.e_lane == 8'hF7));
    chk({tag, " speed_change"}, int'(o_speed_change), int'(v.e_spd));
    chk({tag, " consec_cnt"}, int'(o_consec_cnt), v.e_cnt);
    chk({tag, " ts_8"}, int'(o_ts_8), int'(v.e_cnt >= 8));
  endtask

  task automatic send(input vec_t v, input bit flip_gen, input bit rst_last);
    int n;
    n = len_of(v.kind);
    gen = v.gen;
    for (int i = 0; i < n; i++) begin
      put_sym(v, i, i == 0);
      cnt_rst = rst_last && (i == n - 1);
      @(posedge clk); #1;
      if (flip_gen && (i == 0)) gen = ~v.gen;
    end
    cnt_rst = 1'b0;
    exp_pulses++;
    if (v.e_err) exp_errs++;
  endtask

  task automatic idle(input int n);
    os_if.i_valid    = 1'b0;
    os_if.i_os_start = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    vec_t a, b;
    os_if.i_OS = '0; os_if.i_K = '0; os_if.i_valid = 1'b0; os_if.i_os_start = 1'b0;

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset type", int'(o_type), 7);
    chk("reset os_valid", int'(o_os_valid), 0);
    chk("reset err", int'(o_err), 0);
    chk("reset consec_cnt", int'(o_consec_cnt), 0);
    chk("reset ts_8", int'(o_ts_8), 0);
    chk("reset link_num", int'(o_link_num), 0);
    chk("reset lanepad", int'({o_link_pad, o_lane_pad, o_speed_change}), 0);
    rst = 1'b1;

    for (int i = 0; i < 8; i++)
      tbl[i] = mk(K_TS1H, 1, 8'd5, 8'd0, 0, -1, -1, 8'h00, 3'd0, 0, 8'd5, 8'd0, 0, i + 1);
    for (int i = 8; i < 12; i++)
      tbl[i] = mk(K_TS2H, 1, 8'd5, 8'd0, 0, -1, -1, 8'h00, 3'd1, 0, 8'd5, 8'd0, 0, i - 7);
    tbl[12] = mk(K_TS2H, 1, 8'd6, 8'd0, 0, -1, -1, 8'h00, 3'd1, 0, 8'd6, 8'd0, 0, 1);
    tbl[13] = mk(K_EIOS, 0, 8'd0, 8'd0, 0, -1, -1, 8'h00, 3'd4, 0, 8'd6, 8'd0, 0, 1);
    tbl[14] = mk(K_TS1L, 0, 8'd3, 8'd2, 0, -1, -1, 8'h00, 3'd0, 0, 8'd3, 8'd2, 0, 1);
    tbl[15] = mk(K_SKPL, 0, 8'd0, 8'd0, 0, -1, -1, 8'h00, 3'd3, 0, 8'd3, 8'd2, 0, 1);
    tbl[16] = mk(K_SKPH, 1, 8'd0, 8'd0, 0, -1, -1, 8'h00, 3'd3, 0, 8'd3, 8'd2, 0, 1);
    tbl[17] = mk(K_SDS,  1, 8'd0, 8'd0, 0, -1, -1, 8'h00, 3'd2, 0, 8'd3, 8'd2, 0, 1);
    tbl[18] = mk(K_EIEOS, 1, 8'd0, 8'd0, 0, -1, -1, 8'h00, 3'd5, 0, 8'd3, 8'd2, 0, 1);
    tbl[19] = mk(K_TS1L, 0, 8'd3, 8'd2, 0, -1, -1, 8'h00, 3'd0, 0, 8'd3, 8'd2, 0, 2);
    tbl[20] = mk(K_TS1H, 1, 8'd3, 8'd2, 0, 0, 9, 8'h45, 3'd7, 1, 8'd3, 8'd2, 0, 0);
    tbl[21] = mk(K_TS1H, 1, 8'hF7, 8'hF7, 0, -1, -1, 8'h00, 3'd0, 0, 8'hF7, 8'hF7, 0, 1);
    tbl[22] = mk(K_TS1H, 1, 8'hF7, 8'hF7, 1, -1, -1, 8'h00, 3'd0, 0, 8'hF7, 8'hF7, 1, 1);
`ifdef OS_RX_LANE_CHECK_EN
    tbl[23] = mk(K_TS1H, 1, 8'hF7, 8'hF7, 1, 17, 10, 8'h00, 3'd7, 1, 8'hF7, 8'hF7, 1, 0);
`else
    tbl[23] = mk(K_TS1H, 1, 8'hF7, 8'hF7, 1, 17, 10, 8'h00, 3'd0, 0, 8'hF7, 8'hF7, 1, 2);
`endif
    tbl[24] = mk(K_GARB, 0, 8'd0, 8'd0, 0, -1, -1, 8'h00, 3'd7, 1, 8'hF7, 8'hF7, 1, 0);

    for (int i = 0; i < 25; i++) begin
      send(tbl[i], 0, 0);
      check_vec($sformatf("vec%0d", i), tbl[i]);
    end
    idle(1);
    chk("pulse end os_valid", int'(o_os_valid), 0);
    chk("pulse end err", int'(o_err), 0);

    // Abort at symbol 7, then the restarted set completes normally.
    a = mk(K_TS1H, 1, 8'd9, 8'd1, 0, -1, -1, 8'h00, 3'd0, 0, 8'd9, 8'd1, 0, 1);
    gen = 1'b1;
    for (int i = 0; i < 7; i++) begin put_sym(a, i, i == 0); @(posedge clk); #1; end
    put_sym(a, 0, 1'b1);
    @(posedge clk); #1;
    chk("abort err", int'(o_err), 1);
    chk("abort os_valid", int'(o_os_valid), 0);
    exp_errs++;
    for (int i = 1; i < 16; i++) begin put_sym(a, i, 1'b0); @(posedge clk); #1; end
    exp_pulses++;
    check_vec("abort restart", a);
    idle(2);

    // Stall cycles (i_valid low, stray i_os_start) between every symbol.
    b = a; b.e_cnt = 2;
    for (int i = 0; i < 16; i++) begin
      put_sym(b, i, i == 0);
      @(posedge clk); #1;
      if (i < 15) begin
        os_if.i_valid = 1'b0; os_if.i_os_start = 1'b1;
        @(posedge clk); #1;
      end
    end
    exp_pulses++;
    check_vec("gapped", b);

    b.e_cnt = 0;
    send(b, 0, 1);
    check_vec("cnt_rst priority", b);
    b.e_cnt = 1;
    send(b, 0, 0);
    check_vec("after cnt_rst", b);

    b = mk(K_TS2H, 1, 8'd9, 8'd1, 0, -1, -1, 8'h00, 3'd1, 0, 8'd9, 8'd1, 0, 1);
    send(b, 1, 0);
    check_vec("gen held", b);

    idle(1);
    cnt_rst = 1'b1;
    @(posedge clk); #1;
    cnt_rst = 1'b0;
    chk("idle cnt_rst cnt", int'(o_consec_cnt), 0);
    chk("idle cnt_rst type kept", int'(o_type), 1);
    idle(2);

    chk("os_valid pulse total", n_pulses, exp_pulses);
    chk("err pulse total", n_errs, exp_errs);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/os_receiver.md
Name: os_receiver

Overview:
- Receive-side counterpart of the Tx ordered-set generator.
- Accepts one symbol time per valid cycle across all lanes, delimits 4- and 16-symbol ordered sets, and classifies each one.
- Extracts TS header fields and counts consecutive identical TS1/TS2.
- Reports results to the LTSSM, which uses them for its "8 consecutive TS" style transition conditions.

Parameters:
- DATA_WIDTH, 256, symbol-time data width (8 bits x MAX_LANES)
- MAX_LANES, 32, number of lanes
- LINK_NUM_WIDTH, 8, link number field width
- CONFIG_WIDTH, 3, OS type encoding width
- CNT_WIDTH, 10, consecutive-OS counter width

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-low reset
- i_OS  input  DATA_WIDTH  one symbol per lane; lane i occupies bits [i*8 +: 8], vector declared [0:DATA_WIDTH-1]
- i_K  input  MAX_LANES  K-symbol flag per lane (low gen only)
- i_valid  input  1  symbol time present this cycle
- i_os_start  input  1  qualifies i_OS as symbol 0 of an ordered set (block-aligned)
- gen  input  1  0 = low gen (8b/10b), 1 = high gen
- cnt_rst  input  1  LTSSM clears consecutive counter and flags
- o_type  output  CONFIG_WIDTH  TS1=0, TS2=1, SDS=2, CTL_SKP=3, EIOS=4, EIEOS=5, UNKNOWN=7
- o_os_valid  output  1  one-cycle pulse: o_type and fields are updated
- o_link_num  output  LINK_NUM_WIDTH  lane-0 symbol 1 of last TS
- o_lane_num  output  8  lane-0 symbol 2 of last TS
- o_link_pad / o_lane_pad  output  1 each  lane-0 symbol 1 / symbol 2 was PAD (F7)
- o_speed_change  output  1  bit 0 of symbol 4 of last TS
- o_consec_cnt  output  CNT_WIDTH  consecutive identical TS count
- o_ts_8  output  1  o_consec_cnt >= 8
- o_err  output  1  one-cycle pulse: malformed OS

Behaviour:
- Reset (rst low at posedge): FSM in IDLE; all outputs 0 except o_type = 7.
- FSM states:
  - IDLE: waits for i_valid && i_os_start; captures symbol 0 and moves to COLLECT.
  - COLLECT: the 4-bit symbol counter advances only on i_valid. The final symbol (3 for short sets, 15 otherwise) moves to REPORT.
  - REPORT: lasts one cycle and asserts o_os_valid/o_err. If i_valid && i_os_start occur in REPORT, that symbol is captured as a new symbol 0, giving back-to-back sets with no lost symbol.
- i_os_start in COLLECT before the final symbol: current set is aborted (o_err pulse in the next cycle, no o_os_valid) and restarts at symbol 0.
- Low-gen classification, symbol 0 = COM (BC) with K:
  - symbol 1 = 7C → EIOS, length 4
  - symbol 1 = 1C → CTL_SKP, length 4
  - otherwise TS, length 16; symbols 6..15 all 4A → TS1, all 45 → TS2, else UNKNOWN + o_err
  - symbol 0 not COM → UNKNOWN + o_err, length 16
- High-gen classification by symbol 0, length 16:
  - 1E → TS1 (ID 4A); 2D → TS2 (ID 45)
  - E1 → SDS, symbols 1..15 = 87
  - 99 → CTL_SKP: 99 through symbol 11, symbol 12 = 78 or E1, symbols 13..15 don't care
  - 00 → EIEOS: symbols 0-3 and 8-11 = 00, symbols 4-7 and 12-15 = FF
  - any mismatch → UNKNOWN + o_err
- Latency: o_os_valid is high exactly one cycle after the final symbol is accepted.
- Field registers update only on a valid TS1/TS2. Non-TS sets update only o_type.
- Consecutive count, on each valid TS:
  - same type and same link_num/lane_num/speed_change/pad flags as previous TS → increment, saturating at 2^CNT_WIDTH-1
  - otherwise → load 1
- UNKNOWN or errored sets load 0. SKP, SDS, EIOS and EIEOS leave the count unchanged.
- cnt_rst clears o_consec_cnt and o_ts_8 and has priority over a same-cycle increment. It does not affect the FSM.
- gen is sampled at symbol 0 and held for the whole set.

Optional Feature:
- OS_RX_LANE_CHECK_EN defined:
  - every active lane must carry the lane-0 symbol in symbols 0 and 3..15
  - symbols 1-2 are excluded per lane, since they legitimately carry per-lane numbers or PAD
  - any mismatch → o_err and the set is classified UNKNOWN
- Undefined: lanes 1..MAX_LANES-1 are ignored for classification.

Decomposition:
- Shared package os_pkg holds:
  - OS type encoding, symbol constants (COM, PAD, TS1/TS2 first symbols and IDs, SDS, SKP, EIOS, EIEOS)
  - typedef ts_fields_t {link_num, lane_num, link_pad, lane_pad, speed_change}
- The Tx generator imports the same package.
- One sub-module, os_consec_counter: compares ts_fields_t/type against the previous TS, and owns the saturating count and o_ts_8.

Test Plan:
- High gen: 8 identical TS1 sets (link 5, lane 0, speed_change 0) back-to-back → 8 o_os_valid pulses, type 0, o_consec_cnt 1..8, o_ts_8 rises after the 8th.
- 4 TS2 with link 5 then 1 TS2 with link 6 → count 4, then reloads to 1; o_link_num = 6.
- Low gen: COM,7C,7C,7C with K → o_type = 4, length 4; the next set starts immediately in the REPORT cycle.
- High-gen TS1 with symbol 9 = 45 → o_err pulse, o_type = 7, count = 0.
- i_os_start at symbol 7 of a TS1 → o_err, new set decoded correctly.
- With OS_RX_LANE_CHECK_EN: lane 17 symbol 10 corrupted → o_err. Without it: decodes as TS1.
